// File: rtl/radio_enable_sequencer.sv
// Radio on-window sequencer: round-robin grant between two requesters, then WARMUP -> ON -> GUARD.
// Optional feature macro: RADIO_SEQ_ABORT_STATS_EN adds a saturating accepted-abort counter.
module radio_enable_sequencer #(
  parameter int CNT_W  = 16,
  parameter int WARMUP = 8,
  parameter int GUARD  = 4
) (
  input  logic             ck,
  input  logic             arst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] dur0,
  input  logic [CNT_W-1:0] dur1,
  input  logic             abort,
  output logic [1:0]       grant,
  output logic             radio_enable,
  output logic             rf_valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       abort_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_ON, S_GUARD} state_t;

  localparam logic [CNT_W-1:0] WARMUP_LOAD = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] dur_q_reg, dur_q_next;
  logic             last_reg, last_next;
  logic             win;
  logic [CNT_W-1:0] dur_sel;
  logic [1:0]       grant_reg, grant_next;
  logic             radio_enable_reg, rf_valid_reg, busy_reg, done_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dur_q_next = dur_q_reg;
    last_next  = last_reg;
    grant_next = grant_reg;
    win        = 1'b0;
    dur_sel    = dur0;
    unique case (state_reg)
      S_IDLE: begin
        grant_next = 2'b00;
        if (req != 2'b00) begin
          // Both requesting: the one not served last wins.
          if (req == 2'b11) win = ~last_reg;
          else              win = req[1];
          dur_sel    = win ? dur1 : dur0;
          grant_next = win ? 2'b10 : 2'b01;
          last_next  = win;
          dur_q_next = (dur_sel == '0) ? CNT_W'(1) : dur_sel;
          cnt_next   = WARMUP_LOAD;
          state_next = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (abort) begin
          cnt_next   = GUARD_LOAD;
          state_next = S_GUARD;
        end else if (cnt_reg == '0) begin
          cnt_next   = dur_q_reg - CNT_W'(1);
          state_next = S_ON;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_ON: begin
        if (abort || cnt_reg == '0) begin
          cnt_next   = GUARD_LOAD;
          state_next = S_GUARD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_GUARD: begin
        if (cnt_reg == '0) begin
          grant_next = 2'b00;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge ck) begin
    if (arst) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      dur_q_reg        <= '0;
      last_reg         <= 1'b1;
      grant_reg        <= 2'b00;
      radio_enable_reg <= 1'b0;
      rf_valid_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      dur_q_reg        <= dur_q_next;
      last_reg         <= last_next;
      grant_reg        <= grant_next;
      radio_enable_reg <= (state_next == S_WARMUP) || (state_next == S_ON);
      rf_valid_reg     <= (state_next == S_ON);
      busy_reg         <= (state_next != S_IDLE);
      done_reg         <= (state_next == S_GUARD) && (cnt_next == '0);
    end
  end

  assign grant        = grant_reg;
  assign radio_enable = radio_enable_reg;
  assign rf_valid     = rf_valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

`ifdef RADIO_SEQ_ABORT_STATS_EN
  logic       abort_hit;
  logic [7:0] abort_cnt_reg;

  assign abort_hit = abort && ((state_reg == S_WARMUP) || (state_reg == S_ON));

  always_ff @(posedge ck) begin
    if (arst)                                   abort_cnt_reg <= 8'd0;
    else if (abort_hit && abort_cnt_reg != 8'hFF) abort_cnt_reg <= abort_cnt_reg + 8'd1;
  end

  assign abort_cnt = abort_cnt_reg;
`else
  assign abort_cnt = 8'd0;
`endif

endmodule

// File: doc/radio_enable_sequencer.md
# radio_enable_sequencer

Timing-engine controller that schedules radio on-windows for two requesters and drives the radio enable request that the synchronized radio-enable register consumes. The block arbitrates round-robin between requesters and sequences each granted window through warm-up, on-time and guard phases. A requester may also abort its window early. It sits in the timing engine, upstream of the radio-enable synchronizer and register stage.

## Interface
- CNT_W, 16, width of the duration inputs and the phase counter
- WARMUP, 8, warm-up cycles before the on-window; range 1..2^CNT_W-1
- GUARD, 4, guard cycles after the on-window; range 1..2^CNT_W-1

- ck  in  1  clock
- arst  in  1  reset; synchronous, active-high, sampled on posedge ck
- req  in  2  per-requester window request; level, sampled only in IDLE
- dur0  in  CNT_W  requester 0 on-window length in cycles; latched at grant
- dur1  in  CNT_W  requester 1 on-window length in cycles; latched at grant
- abort  in  1  ends the current WARMUP or ON phase early
- grant  out  2  one-hot owner of the current window; held through WARMUP, ON and GUARD
- radio_enable  out  1  radio enable request; high in WARMUP and ON
- rf_valid  out  1  high in ON only
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse in the last GUARD cycle
- abort_cnt  out  8  saturating count of accepted aborts; see Configuration

## Operation
- The FSM has four states: IDLE, WARMUP, ON and GUARD. All outputs are registered.
- **IDLE**
  - Entered on reset or at the end of GUARD.
  - If req is nonzero, grant one requester, latch its dur into dur_q and go to WARMUP with cnt=WARMUP-1.
  - A dur value of 0 is latched as 1.
- **Arbitration**
  - Round-robin on a last-grant bit, which resets to 1 so requester 0 wins first.
  - With a single request, that requester wins.
  - With both requesting, the winner is the requester that was not granted last.
  - last is updated at every grant.
- **WARMUP**
  - cnt decrements each cycle.
  - When cnt==0, go to ON with cnt=dur_q-1.
- **ON**
  - cnt decrements each cycle.
  - When cnt==0, go to GUARD with cnt=GUARD-1.
- **GUARD**
  - cnt decrements each cycle.
  - done=1 when cnt==0; the next state is IDLE and grant clears.
- **abort**
  - In WARMUP or ON, abort takes priority over counter expiry: go to GUARD with cnt=GUARD-1.
  - abort is ignored in IDLE and GUARD.
- **req changes after grant:** ignored. Deasserting req mid-window does not end the window; only abort does.
- **Reset values:** grant=0, radio_enable=0, rf_valid=0, busy=0, done=0, abort_cnt=0, state=IDLE, last=1. Reset mid-window returns to IDLE at the next edge with no done pulse.
- **Counter width:** cnt is CNT_W bits and never wraps; every load value is at least 0.

## Timing
- Let cycle t be the IDLE cycle in which req is sampled.
  - WARMUP occupies t+1..t+WARMUP.
  - ON occupies the next dur_q cycles.
  - GUARD occupies the next GUARD cycles.
- grant, busy and radio_enable rise at t+1. rf_valid rises with the first ON cycle.
- radio_enable and rf_valid fall together at the first GUARD cycle.
- done coincides with the last GUARD cycle. busy falls the cycle after done.
- IDLE always lasts at least one cycle between windows. Back-to-back windows therefore have a 1-cycle IDLE gap.
- An abort sampled in cycle a makes a+1 the first GUARD cycle.

## Configuration
- The macro is RADIO_SEQ_ABORT_STATS_EN.
- Defined: abort_cnt increments by 1 on each accepted abort (WARMUP or ON only) and saturates at 255. It clears only on reset.
- Undefined: abort_cnt is tied to 0 and no counter register is built. The port list is unchanged.

## Test plan
All scenarios use WARMUP=3 and GUARD=2.
- **Single window:** req=01, dur0=4 at IDLE cycle t.
  - grant=01 and radio_enable=1 over t+1..t+7.
  - rf_valid=1 over t+4..t+7.
  - done=1 at t+9; busy=0 at t+10.
- **Contention:** req=11 held, dur0=dur1=2.
  - Grants alternate 01, 10, 01.
  - Each window is 7 busy cycles, separated by exactly 1 IDLE cycle.
- **Abort:** abort pulsed in the second ON cycle with dur1=10.
  - The first GUARD cycle follows the abort cycle immediately; rf_valid falls then.
  - done arrives 2 cycles later.
  - abort_cnt=1 with the macro defined, 0 without.
- **Zero duration:** dur0=0.
  - ON lasts exactly 1 cycle; total busy is 6 cycles.
- **Reset mid-ON:** arst=1 for one cycle during ON.
  - At the next edge all outputs are 0 and state is IDLE, with no done pulse.
  - After reset, req=11 grants requester 0 first.
- **Ignored inputs:** abort asserted in IDLE or GUARD, and req dropped mid-window.
  - Timing is identical to the single-window scenario and abort_cnt does not change.
